// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core: merges stage stall requests,
// holds redirects until outstanding bus transfers drain, counts stall cycles.
module pipeline_ctrl #(
    parameter int PC_W         = 32,
    parameter int PERF_W       = 32,
    parameter int TO_W         = 8,
    parameter int BUS_WAIT_MAX = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_stall_req,
    input  logic              ex_stall_req,
    input  logic              mem_stall_req,
    input  logic              exc_valid,
    input  logic [PC_W-1:0]   exc_target,
    input  logic              eret_valid,
    input  logic [PC_W-1:0]   epc,
    input  logic              perf_clr,
    output logic [5:0]        stall,
    output logic              flush,
    output logic              new_pc_valid,
    output logic [PC_W-1:0]   new_pc,
    output logic              bus_timeout,
    output logic [PERF_W-1:0] stall_cycles
);

    // state    | meaning
    // RUN      | normal flow, stall from merged requests
    // WAIT_BUS | redirect pending, hold pipe until IF/MEM bus idle
    // FLUSH    | one cycle: clear pipe registers, load latched target
    typedef enum logic [1:0] {RUN, WAIT_BUS, FLUSH} state_t;

    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(BUS_WAIT_MAX - 1);

    state_t            state;
    logic [TO_W-1:0]   wait_cnt;
    logic [PC_W-1:0]   target;
    logic              redirect;
    logic              bus_busy;

    assign redirect = exc_valid | eret_valid;
    assign bus_busy = if_stall_req | mem_stall_req;

    always_comb begin
        stall = 6'b000000;
        case (state)
            RUN: begin
                if (redirect || mem_stall_req) stall = 6'b011111;
                else if (ex_stall_req)         stall = 6'b001111;
                else if (if_stall_req)         stall = 6'b000011;
            end
            WAIT_BUS: stall = 6'b011111;
            default:  stall = 6'b000000;
        endcase
        if (rst) stall = 6'b000000;
    end

    assign flush        = (state == FLUSH);
    assign new_pc_valid = (state == FLUSH);
    assign new_pc       = target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            target       <= '0;
            bus_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (perf_clr)
                stall_cycles <= '0;
            else if ((|stall) && (stall_cycles != '1))
                stall_cycles <= stall_cycles + PERF_W'(1);

            case (state)
                RUN: begin
                    if (redirect) begin
                        target <= exc_valid ? exc_target : epc;
                        state  <= bus_busy ? WAIT_BUS : FLUSH;
                    end
                end
                WAIT_BUS: begin
                    // A bus release in the same cycle as expiry is not a timeout.
                    if (!bus_busy) begin
                        state    <= FLUSH;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        bus_timeout <= 1'b1;
                        state       <= FLUSH;
                        wait_cnt    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                FLUSH:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule
